// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction-memory address,
// captures the returned word into IR and hands it to decode.
module fetch_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_DEPTH   = 256,
  parameter int RESET_PC    = 0,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic                  decode_ack,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] ir,
  output logic                  ir_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic                  busy,
  output logic [15:0]           fetch_count,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2,
    S_HOLD    = 2'd3
  } state_t;

  localparam logic [3:0]            WAIT_INIT   = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam state_t                FETCH_START = (WAIT_CYCLES > 0) ? S_WAIT : S_CAPTURE;
  localparam logic [ADDR_WIDTH-1:0] PC_RST      = ADDR_WIDTH'(RESET_PC);
  localparam logic [ADDR_WIDTH-1:0] PC_LAST     = ADDR_WIDTH'(MEM_DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] ir_pc_q, ir_pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  ir_valid_q, ir_valid_d;
  logic                  busy_q, busy_d;
  logic [15:0]           count_q, count_d;
  logic [3:0]            wait_q, wait_d;

  logic [ADDR_WIDTH-1:0] pc_in_mod;
  logic [ADDR_WIDTH-1:0] pc_next;

  // A depth that covers the whole address space needs no reduction.
  if (MEM_DEPTH >= (1 << ADDR_WIDTH)) begin : g_full
    assign pc_in_mod = pc_in;
  end else begin : g_mod
    assign pc_in_mod = pc_in % ADDR_WIDTH'(MEM_DEPTH);
  end

  assign pc_next = (pc_q == PC_LAST) ? '0 : pc_q + ADDR_WIDTH'(1);

  // Handshake: ir_valid high means IR holds an unconsumed instruction; it is
  // consumed on a clock edge where decode_ack is also high. ack with valid low is ignored.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_pc_d    = ir_pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    count_d    = count_q;
    wait_d     = wait_q;
    case (state_q)
      S_IDLE: begin
        if (pc_load) begin
          pc_d = pc_in_mod;
        end else if (fetch_req) begin
          state_d = FETCH_START;
          wait_d  = WAIT_INIT;
        end
      end
      S_WAIT: begin
        if (wait_q == 4'd0) state_d = S_CAPTURE;
        else                wait_d  = wait_q - 4'd1;
      end
      S_CAPTURE: begin
        ir_d       = imem_data;
        ir_pc_d    = pc_q;
        pc_d       = pc_next;
        ir_valid_d = 1'b1;
        count_d    = count_q + 16'd1;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (pc_load) pc_d = pc_in_mod;
        if (decode_ack) begin
          ir_valid_d = 1'b0;
          if (fetch_req && !pc_load) begin
            state_d = FETCH_START;
            wait_d  = WAIT_INIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_WAIT) || (state_d == S_CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= PC_RST;
      ir_pc_q    <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      count_q    <= 16'd0;
      wait_q     <= 4'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_pc_q    <= ir_pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign ir          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign busy        = busy_q;
  assign fetch_count = count_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the multicycle processor.
- Owns the program counter and drives the word address into the combinational instruction memory.
- Captures the returned 16-bit word into the instruction register (IR) and presents it to decode/control under a valid/ack handshake.
- Accepts PC redirects for branches and jumps from the control unit.

Parameters:
- ADDR_WIDTH, 16, width of PC and instruction-memory address.
- DATA_WIDTH, 16, instruction width.
- MEM_DEPTH, 256, number of instruction words; PC wraps modulo MEM_DEPTH.
- RESET_PC, 0, PC value after reset.
- WAIT_CYCLES, 0, extra cycles between address drive and IR capture (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  control requests the next instruction.
- decode_ack  in  1  decode has consumed the IR.
- pc_load  in  1  redirect PC (branch/jump taken).
- pc_in  in  ADDR_WIDTH  redirect target.
- imem_addr  out  ADDR_WIDTH  address to instruction memory.
- imem_data  in  DATA_WIDTH  instruction word from memory (combinational).
- ir  out  DATA_WIDTH  instruction register.
- ir_valid  out  1  IR holds an unconsumed instruction.
- pc  out  ADDR_WIDTH  current PC (address of next fetch).
- ir_pc  out  ADDR_WIDTH  address the current IR was fetched from.
- busy  out  1  high in FETCH/WAIT.
- fetch_count  out  16  instructions captured since reset; wraps.

Behaviour:
- Reset (synchronous, active-high; the only reset): state=IDLE, pc=RESET_PC, ir=0, ir_pc=0, ir_valid=0, busy=0, fetch_count=0, wait counter=0. Reset mid-fetch aborts the fetch with no IR update.
- imem_addr is combinationally equal to pc at all times.
- States: IDLE, WAIT, CAPTURE, HOLD.
- IDLE:
  - If pc_load: pc<=pc_in mod MEM_DEPTH and stay in IDLE. pc_load has priority; fetch_req is ignored that cycle.
  - Else if fetch_req: go to WAIT if WAIT_CYCLES>0 (counter<=WAIT_CYCLES-1), else go to CAPTURE.
- WAIT: decrement counter; go to CAPTURE when counter==0. pc_load is ignored.
- CAPTURE (one cycle): on the clock edge, ir<=imem_data, ir_pc<=pc, pc<=(pc+1) mod MEM_DEPTH, ir_valid<=1, fetch_count<=fetch_count+1; go to HOLD. pc_load is ignored.
- busy=1 in WAIT and CAPTURE.
- Fetch latency: fetch_req accepted at edge N means the IR is valid after edge N+1+WAIT_CYCLES.
- HOLD: ir and ir_valid are stable until decode_ack.
  - If pc_load (with or without decode_ack): pc<=pc_in; ir_valid stays unchanged unless decode_ack is also high.
  - If decode_ack: ir_valid<=0. If fetch_req is also high and pc_load is low, go straight to WAIT/CAPTURE (back-to-back fetch); else go to IDLE.
  - If decode_ack and pc_load are both high, go to IDLE with the new pc.
- decode_ack while ir_valid=0: ignored.
- fetch_req outside IDLE/HOLD: ignored and not queued.
- PC wrap: pc=MEM_DEPTH-1 captures, then pc=0. pc_in>=MEM_DEPTH is reduced modulo MEM_DEPTH.
- fetch_count wraps 0xFFFF -> 0x0000.
- ir holds its last value when ir_valid drops.

Test Plan:
- Reset, WAIT_CYCLES=0, mem[0]=0x00A3, fetch_req pulse -> one cycle later ir=0x00A3, ir_valid=1, ir_pc=0, pc=1, fetch_count=1; after decode_ack, ir_valid=0 and state IDLE.
- Back-to-back: mem[1]=0xA032, mem[2]=0x9036; hold fetch_req=1 and decode_ack=1 whenever ir_valid -> ir sequence 0x00A3, 0xA032, 0x9036 on every second cycle; pc reaches 3.
- Redirect: in IDLE, pc_load=1 with pc_in=0x0080 and fetch_req=1 in the same cycle -> pc=0x0080, no fetch; next fetch_req gives ir_pc=0x0080, pc=0x0081.
- Wrap: pc_load pc_in=0x00FF, fetch -> ir_pc=0x00FF, pc=0x0000. Then pc_in=0x0105 -> pc=0x0005.
- WAIT_CYCLES=3: fetch_req accepted at edge N -> busy high for 4 cycles, ir_valid rises after edge N+4; pc_load during WAIT is ignored and pc is unchanged.
- Reset asserted during WAIT (WAIT_CYCLES=3) -> next cycle state IDLE, ir_valid=0, ir=0, pc=RESET_PC, fetch_count=0.
